// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID output register and a one-entry skid buffer.
// Issues single-outstanding requests over a req/ack handshake, holds one extra
// word while decode stalls, and redirects on a taken branch from execute.
// Optional build macro FETCH_PERF_CNT_EN adds kept-fetch and flush counters.
module fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [31:0]         inst_code,
  output logic [PC_WIDTH-1:0] pc_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt,
`endif
  output logic                inst_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));
  localparam logic [PC_WIDTH-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic                req_n;
  logic [PC_WIDTH-1:0] addr_n;
  logic [31:0]         code_n;
  logic [PC_WIDTH-1:0] pcout_n;
  logic                valid_n;
  logic [31:0]         skid_inst, skid_inst_n;
  logic [PC_WIDTH-1:0] skid_pc, skid_pc_n;

  logic                accept;
  logic                drain;
  logic                kept;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_plus4;

  assign accept   = imem_req & imem_ack;
  assign drain    = ~stall | ~inst_valid;
  assign target   = branch_target & ALIGN_MASK;
  assign pc_plus4 = pc + PC_WIDTH'(4);

  // Next-state and next-register logic; a taken branch overrides everything.
  // The skid buffer is full exactly when the FSM sits in HOLD.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_n       = imem_req;
    addr_n      = imem_addr;
    code_n      = inst_code;
    pcout_n     = pc_out;
    valid_n     = inst_valid;
    skid_inst_n = skid_inst;
    skid_pc_n   = skid_pc;
    kept        = 1'b0;

    if (branch_taken) begin
      pc_n    = target;
      valid_n = 1'b0;
      code_n  = NOP_INST;
      unique case (state)
        FETCH: begin
          if (imem_req && !imem_ack) begin
            state_n = DISCARD;
          end else begin
            req_n  = 1'b1;
            addr_n = target;
          end
        end
        HOLD: begin
          state_n = FETCH;
          req_n   = 1'b1;
          addr_n  = target;
        end
        DISCARD: begin
          if (accept) begin
            state_n = FETCH;
            addr_n  = target;
          end
        end
        default: state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (!imem_req) begin
            req_n  = 1'b1;
            addr_n = pc;
          end
          if (accept) begin
            kept = 1'b1;
            pc_n = pc_plus4;
            if (drain) begin
              code_n  = imem_rdata;
              pcout_n = imem_addr;
              valid_n = 1'b1;
              addr_n  = pc_plus4;
            end else begin
              skid_inst_n = imem_rdata;
              skid_pc_n   = imem_addr;
              req_n       = 1'b0;
              state_n     = HOLD;
            end
          end else if (!stall) begin
            valid_n = 1'b0;
            code_n  = NOP_INST;
          end
        end
        HOLD: begin
          if (!stall) begin
            code_n  = skid_inst;
            pcout_n = skid_pc;
            valid_n = 1'b1;
            req_n   = 1'b1;
            addr_n  = pc;
            state_n = FETCH;
          end
        end
        DISCARD: begin
          if (accept) begin
            addr_n  = pc;
            state_n = FETCH;
          end
          if (!stall) begin
            valid_n = 1'b0;
            code_n  = NOP_INST;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // State, request, IF/ID output and skid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_ADDR;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_ADDR;
      inst_code  <= NOP_INST;
      pc_out     <= RESET_ADDR;
      inst_valid <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      imem_req   <= req_n;
      imem_addr  <= addr_n;
      inst_code  <= code_n;
      pc_out     <= pcout_n;
      inst_valid <= valid_n;
      skid_inst  <= skid_inst_n;
      skid_pc    <= skid_pc_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count words actually kept and every cycle a flush is requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (kept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (branch_taken) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  logic unused_kept;
  assign unused_kept = kept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: zero-wait streaming, stall/skid,
// branch during wait states, branch with full skid, async reset and PC wrap.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, stall, branch_taken, inst_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, inst_code, pc_out;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, code2, pcout2;
  logic        stall2 = 1'b0;
  logic        branch2 = 1'b0;
  logic [31:0] target2 = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [97:0] got, exp;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .inst_code(inst_code), .pc_out(pc_out), .inst_valid(inst_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .stall(stall2), .branch_taken(branch2), .branch_target(target2),
    .inst_code(code2), .pc_out(pcout2), .inst_valid(valid2)
  );

  // 10-unit clock; checks and input changes happen on the falling edge.
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h00500093;
      32'h4:   mem_word = 32'h00A00113;
      32'h8:   mem_word = 32'h00F00193;
      default: mem_word = a ^ 32'h5A5A0003;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; ack2 = 1'b0; rdata2 = '0;
    step(); step();
    got = {imem_req, imem_addr, inst_valid, inst_code, pc_out};
    exp = {1'b0, 32'h0, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_state got=%h exp=%h", got, exp); end
    got = {req2, addr2, valid2, code2, pcout2};
    exp = {1'b0, 32'hFFFFFFF8, 1'b0, NOP, 32'hFFFFFFF8};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_state_wrap got=%h exp=%h", got, exp); end
  endtask

  task automatic test_basic();
    reset = 1'b0;
    step();
    got = {imem_req, imem_addr, inst_valid, 64'h0};
    exp = {1'b1, 32'h0, 1'b0, 64'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL first_req got=%h exp=%h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = mem_word(32'(i * 4));
      step();
      got = {imem_req, imem_addr, inst_valid, inst_code, pc_out};
      exp = {1'b1, 32'(i * 4 + 4), 1'b1, mem_word(32'(i * 4)), 32'(i * 4)};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL stream_%0d got=%h exp=%h", i, got, exp); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ack = 1'b0;
      got = {imem_req, 32'h0, inst_valid, inst_code, pc_out};
      exp = {1'b0, 32'h0, 1'b1, 32'h00F00193, 32'h8};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL stall_hold_%0d got=%h exp=%h", i, got, exp); end
    end
    stall = 1'b0;
    step();
    got = {imem_req, imem_addr, inst_valid, inst_code, pc_out};
    exp = {1'b1, 32'h10, 1'b1, mem_word(32'hC), 32'hC};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL skid_release got=%h exp=%h", got, exp); end
    step();
    got = {imem_req, imem_addr, inst_valid, inst_code, 32'h0};
    exp = {1'b1, 32'h10, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL no_duplicate got=%h exp=%h", got, exp); end
  endtask

  task automatic test_branch_wait();
    branch_taken = 1'b1; branch_target = 32'h00000103;
    step();
    branch_taken = 1'b0;
    got = {imem_req, imem_addr, inst_valid, inst_code, 32'h0};
    exp = {1'b1, 32'h10, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL discard_hold got=%h exp=%h", got, exp); end
    step();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h10);
    step();
    got = {imem_req, imem_addr, inst_valid, inst_code, 32'h0};
    exp = {1'b1, 32'h100, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL discard_drop got=%h exp=%h", got, exp); end
    imem_rdata = mem_word(32'h100);
    step();
    imem_ack = 1'b0;
    got = {imem_req, imem_addr, inst_valid, inst_code, pc_out};
    exp = {1'b1, 32'h104, 1'b1, mem_word(32'h100), 32'h100};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL target_word got=%h exp=%h", got, exp); end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'h104);
    step();
    imem_ack = 1'b0;
    got = {imem_req, 32'h0, inst_valid, inst_code, pc_out};
    exp = {1'b0, 32'h0, 1'b1, mem_word(32'h100), 32'h100};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL skid_fill got=%h exp=%h", got, exp); end
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    got = {imem_req, imem_addr, inst_valid, inst_code, 32'h0};
    exp = {1'b1, 32'h200, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL branch_flush got=%h exp=%h", got, exp); end
    stall = 1'b0;
    step();
    got = {imem_req, imem_addr, inst_valid, inst_code, 32'h0};
    exp = {1'b1, 32'h200, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL skid_cleared got=%h exp=%h", got, exp); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h200);
    step();
    imem_ack = 1'b0;
    got = {imem_req, imem_addr, inst_valid, inst_code, pc_out};
    exp = {1'b1, 32'h204, 1'b1, mem_word(32'h200), 32'h200};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL resume_target got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid();
    step();
    #2 reset = 1'b1;
    #1;
    got = {imem_req, imem_addr, inst_valid, inst_code, pc_out};
    exp = {1'b0, 32'h0, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL async_reset got=%h exp=%h", got, exp); end
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    reset = 1'b0;
    step();
    got = {imem_req, imem_addr, inst_valid, inst_code, 32'h0};
    exp = {1'b1, 32'h0, 1'b0, NOP, 32'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL stale_ack got=%h exp=%h", got, exp); end
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    a = 32'hFFFFFFF8;
    got = {req2, addr2, 65'h0};
    exp = {1'b1, 32'hFFFFFFF8, 65'h0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL wrap_first got=%h exp=%h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      ack2 = 1'b1; rdata2 = mem_word(a);
      step();
      got = {req2, addr2, valid2, code2, pcout2};
      exp = {1'b1, a + 32'd4, 1'b1, mem_word(a), a};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL wrap_%0d got=%h exp=%h", i, got, exp); end
      a = a + 32'd4;
    end
    ack2 = 1'b0;
  endtask

  // Bound the run in case the sequence ever stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch_wait();
    test_branch_stall();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage with IF/ID pipeline register. Feeds the decode stage, whose immediate generator consumes `inst_code`.
- Holds the PC and issues single-outstanding fetches to instruction memory over a req/ack handshake.
- Buffers one instruction when decode stalls.
- Redirects and flushes on a taken branch from execute.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INST, 32'h00000013, value driven on `inst_code` when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; registered.
- imem_addr  out  PC_WIDTH  fetch address; registered; bits [1:0] always 0.
- imem_ack  in  1  memory returns `imem_rdata` for the outstanding request this cycle.
- imem_rdata  in  32  instruction word, valid when `imem_ack`.
- stall  in  1  decode cannot accept; IF/ID output holds.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  PC_WIDTH  redirect address; bits [1:0] ignored (forced 0).
- inst_code  out  32  IF/ID instruction to decode.
- pc_out  out  PC_WIDTH  address of `inst_code`.
- inst_valid  out  1  `inst_code`/`pc_out` hold a real instruction.

Behaviour:
- Reset (async, any time, including mid-request):
  - pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC.
  - inst_code=NOP_INST, pc_out=RESET_PC, inst_valid=0.
  - Skid buffer empty.
  - First `imem_req`=1 on the first rising edge after reset release.
- Handshake:
  - A request is complete on any cycle with imem_req=1 and imem_ack=1.
  - `imem_req`/`imem_addr` stay stable from assertion until ack.
  - Only one request is outstanding.
  - Ack can arrive the same cycle as req (zero wait) or N cycles later.
  - Next request is issued on the edge of the ack (back-to-back): imem_addr=pc+4, req stays 1.
  - Zero-wait throughput: 1 instruction/cycle.
- Output register:
  - "Drains" when stall=0.
  - On accepted ack with the output draining or inst_valid=0: inst_code<=imem_rdata, pc_out<=imem_addr, inst_valid<=1.
  - Fetch-to-output latency: 1 cycle after ack.
  - When the output drains and no new instruction arrives: inst_valid<=0, inst_code<=NOP_INST.
- FSM states: FETCH, HOLD, DISCARD.
  - FETCH: req=1.
    - Ack while output full and stall=1: word goes to the skid buffer; pc advances; req<=0; go to HOLD.
  - HOLD: req=0; skid buffer full.
    - When stall=0: skid moves to output; req<=1 at pc; go to FETCH.
  - DISCARD: a redirect occurred while a request was outstanding without ack.
    - req and the old address are held until ack; the returned word is dropped.
    - Then imem_addr<=pc (the target); go to FETCH.
- Branch (branch_taken=1) has highest priority, regardless of stall:
  - pc<=target; inst_valid<=0; inst_code<=NOP_INST; skid buffer cleared.
  - FETCH with ack the same cycle: word dropped; next req at target; stay in FETCH.
  - FETCH without ack: go to DISCARD.
  - HOLD: go to FETCH, req at target.
  - DISCARD: pc updated to the newest target; remain in DISCARD.
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH (0xFFFFFFFC -> 0x00000000); no trap.
- Stall and empty output: fetch continues into the empty output; fetch stops only when both output and skid are full.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output `perf_fetch_cnt[31:0]`: counts accepted acks whose word was kept, not dropped.
  - Adds output `perf_flush_cnt[31:0]`: counts branch_taken cycles.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory returning 0x00500093, 0x00A00113, 0x00F00193 -> req at 0x0, 0x4, 0x8 on consecutive cycles; inst_code shows each word one cycle after its ack with pc_out 0x0, 0x4, 0x8; inst_valid=1.
- stall=1 for 3 cycles with output full -> one word captured into skid, then req=0; inst_code/pc_out stable; on stall=0 the skid word appears next cycle with no loss or duplication.
- branch_taken=1, target 0x00000103, while a 3-wait-state request to 0x10 is pending -> DISCARD; the 0x10 word is never visible; next req addr=0x100; inst_valid=0 until the 0x100 word arrives.
- branch_taken together with stall=1 and skid full -> inst_valid=0 and inst_code=0x00000013 the next cycle; skid empty; fetch resumes at the target.
- RESET_PC=0xFFFFFFF8, zero wait -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- reset asserted mid-request with wait states -> outputs return immediately to reset values; the stale ack is ignored; first req after release at RESET_PC.
